// File: rtl/noc_pkg.sv
// Shared NoC definitions: flit-type encodings, port indices and the arbiter state type.
package noc_pkg;

  localparam logic [2:0] FLIT_HEADER  = 3'b001;
  localparam logic [2:0] FLIT_PAYLOAD = 3'b010;
  localparam logic [2:0] FLIT_TAIL    = 3'b100;

  typedef enum logic [2:0] {
    PORT_N = 3'd0,
    PORT_E = 3'd1,
    PORT_W = 3'd2,
    PORT_S = 3'd3,
    PORT_L = 3'd4
  } port_e;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } arb_state_e;

  // Index width that stays legal for a single-input arbiter.
  function automatic int sel_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin selector: first set request at or above i_ptr, wrapping.
module rr_picker #(
  parameter int N     = 5,
  parameter int SEL_W = 3
) (
  input  logic [N-1:0]     i_req,
  input  logic [SEL_W-1:0] i_ptr,
  output logic [N-1:0]     o_gnt,
  output logic [SEL_W-1:0] o_idx,
  output logic             o_any
);

  always_comb begin
    o_gnt = '0;
    o_idx = '0;
    o_any = 1'b0;
    for (int k = 0; k < N; k++) begin
      if (!o_any && i_req[(int'(i_ptr) + k) % N]) begin
        o_any                           = 1'b1;
        o_gnt[(int'(i_ptr) + k) % N]    = 1'b1;
        o_idx                           = SEL_W'((int'(i_ptr) + k) % N);
      end
    end
  end

endmodule

// File: rtl/router_arbiter.sv
// Wormhole output-port arbiter: locks the output to one input from HEADER to TAIL.
// Optional lock-stall timeout enabled by defining ARB_LOCK_TIMEOUT_EN.
//
// state     | meaning
// ST_IDLE   | output unowned; HEADER requests arbitrated round-robin from r_ptr
// ST_LOCKED | output owned by r_sel until its TAIL is popped (or stall timeout)
module router_arbiter
  import noc_pkg::*;
#(
  parameter  int N_IN           = 5,
  parameter  int TIMEOUT_CYCLES = 255,
  localparam int SEL_W          = sel_width(N_IN)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N_IN-1:0]   req,
  input  logic [3*N_IN-1:0] flit_id,
  input  logic              out_ready,
  output logic [N_IN-1:0]   grant,
  output logic [SEL_W-1:0]  sel,
  output logic              out_valid,
  output logic [N_IN-1:0]   pop,
  output logic              busy,
  output logic              timeout_err
);

  arb_state_e       r_state;
  logic [N_IN-1:0]  r_grant;
  logic [SEL_W-1:0] r_sel;
  logic [SEL_W-1:0] r_ptr;
  logic             r_busy;

  logic [N_IN-1:0]  w_cand;
  logic [N_IN-1:0]  w_pick_gnt;
  logic [SEL_W-1:0] w_pick_idx;
  logic             w_pick_any;
  logic [2:0]       w_owner_flit;
  logic             w_out_valid;
  logic             w_fire;
  logic             w_tail_pop;
  logic             w_timeout;
  logic [SEL_W-1:0] w_next_ptr;

  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 1");
  end

  always_comb begin
    w_cand = '0;
    for (int i = 0; i < N_IN; i++)
      w_cand[i] = req[i] && (flit_id[3*i +: 3] == FLIT_HEADER);
  end

  rr_picker #(
    .N     (N_IN),
    .SEL_W (SEL_W)
  ) u_rr_picker (
    .i_req (w_cand),
    .i_ptr (r_ptr),
    .o_gnt (w_pick_gnt),
    .o_idx (w_pick_idx),
    .o_any (w_pick_any)
  );

  // Unknown encodings on the owner fall through as payload: only TAIL releases.
  assign w_owner_flit = flit_id[3*r_sel +: 3];
  assign w_out_valid  = r_busy & req[r_sel];
  assign w_fire       = w_out_valid & out_ready;
  assign w_tail_pop   = w_fire & (w_owner_flit == FLIT_TAIL);
  assign w_next_ptr   = (r_sel == SEL_W'(N_IN - 1)) ? '0 : r_sel + 1'b1;

`ifdef ARB_LOCK_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] r_stall;
  logic             r_timeout_err;

  assign w_timeout = r_busy & ~w_fire & (r_stall == CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_stall       <= '0;
      r_timeout_err <= 1'b0;
    end else begin
      r_timeout_err <= w_timeout;
      if (!r_busy || w_fire || w_timeout)
        r_stall <= '0;
      else
        r_stall <= r_stall + 1'b1;
    end
  end

  assign timeout_err = r_timeout_err;
`else
  assign w_timeout   = 1'b0;
  assign timeout_err = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
      r_grant <= '0;
      r_sel   <= '0;
      r_ptr   <= '0;
      r_busy  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_pick_any) begin
            r_state <= ST_LOCKED;
            r_grant <= w_pick_gnt;
            r_sel   <= w_pick_idx;
            r_busy  <= 1'b1;
          end
        end
        ST_LOCKED: begin
          if (w_tail_pop || w_timeout) begin
            r_state <= ST_IDLE;
            r_grant <= '0;
            r_busy  <= 1'b0;
            r_ptr   <= w_next_ptr;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign grant     = r_grant;
  assign sel       = r_sel;
  assign busy      = r_busy;
  assign out_valid = w_out_valid;
  assign pop       = r_grant & {N_IN{w_fire}};

endmodule

// File: tb/tb_router_arbiter.sv
// Directed self-checking bench for router_arbiter (timeout scenario needs ARB_LOCK_TIMEOUT_EN).
module tb_router_arbiter;

  localparam logic [2:0] H = 3'b001;
  localparam logic [2:0] P = 3'b010;
  localparam logic [2:0] T = 3'b100;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  req;
  logic [2:0]  fid [5];
  logic [14:0] flit_id;
  logic        out_ready;
  logic [4:0]  grant;
  logic [2:0]  sel;
  logic        out_valid;
  logic [4:0]  pop;
  logic        busy;
  logic        timeout_err;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  always_comb begin
    flit_id = '0;
    for (int i = 0; i < 5; i++) flit_id[3*i +: 3] = fid[i];
  end

  router_arbiter #(
    .N_IN           (5),
    .TIMEOUT_CYCLES (8)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req         (req),
    .flit_id     (flit_id),
    .out_ready   (out_ready),
    .grant       (grant),
    .sel         (sel),
    .out_valid   (out_valid),
    .pop         (pop),
    .busy        (busy),
    .timeout_err (timeout_err)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst       = 1'b0;
    req       = '0;
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) fid[i] = 3'b000;
    step();
    step();
    rst = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b0; req = 5'b11111; out_ready = 1'b1;
    for (int i = 0; i < 5; i++) fid[i] = H;
    step();
    checks++; if (grant !== 5'b0) begin failures++; $display("FAIL reset_grant got=%b exp=00000", grant); end
    checks++; if (sel !== 3'd0) begin failures++; $display("FAIL reset_sel got=%0d exp=0", sel); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    checks++; if (pop !== 5'b0) begin failures++; $display("FAIL reset_pop got=%b exp=00000", pop); end
    checks++; if (timeout_err !== 1'b0) begin failures++; $display("FAIL reset_timeout_err got=%b exp=0", timeout_err); end
  endtask

  task automatic test_single();
    do_reset();
    req = 5'b00001; fid[0] = H; out_ready = 1'b0;
    step();
    checks++; if (grant !== 5'b00001) begin failures++; $display("FAIL single_grant got=%b exp=00001", grant); end
    checks++; if (sel !== 3'd0) begin failures++; $display("FAIL single_sel got=%0d exp=0", sel); end
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL single_busy got=%b exp=1", busy); end
    checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL single_out_valid got=%b exp=1", out_valid); end
    checks++; if (pop !== 5'b0) begin failures++; $display("FAIL single_pop_not_ready got=%b exp=00000", pop); end
    fid[0] = T; out_ready = 1'b1;
    #1;
    checks++; if (pop !== 5'b00001) begin failures++; $display("FAIL single_tail_pop got=%b exp=00001", pop); end
    step();
    checks++; if (busy !== 1'b0 || grant !== 5'b0) begin failures++; $display("FAIL single_release got busy=%b grant=%b exp busy=0 grant=00000", busy, grant); end
  endtask

  task automatic test_round_robin();
    int         pos [5];
    logic [4:0] popped;
    logic [4:0] exp_g;
    logic [2:0] exp_s;
    do_reset();
    req = 5'b11111; out_ready = 1'b1; popped = '0;
    for (int i = 0; i < 5; i++) begin fid[i] = H; pos[i] = 0; end
    // Owner k holds cycles 4k+1..4k+3; every 4th cycle is the idle bubble.
    for (int c = 1; c <= 24; c++) begin
      step();
      for (int i = 0; i < 5; i++) begin
        if (popped[i]) begin
          pos[i] = (pos[i] + 1) % 3;
          fid[i] = (pos[i] == 0) ? H : (pos[i] == 1) ? P : T;
        end
      end
      #1;
      exp_g = (c % 4 == 0) ? 5'b0 : (5'b00001 << ((c / 4) % 5));
      exp_s = 3'((c / 4) % 5);
      checks++; if (grant !== exp_g) begin failures++; $display("FAIL rr_grant cycle=%0d got=%b exp=%b", c, grant, exp_g); end
      checks++; if (pop !== exp_g) begin failures++; $display("FAIL rr_pop cycle=%0d got=%b exp=%b", c, pop, exp_g); end
      if (c % 4 != 0) begin
        checks++; if (sel !== exp_s) begin failures++; $display("FAIL rr_sel cycle=%0d got=%0d exp=%0d", c, sel, exp_s); end
      end
      popped = pop;
    end
  endtask

  task automatic test_empty_stall();
    do_reset();
    req = 5'b00100; fid[2] = H; out_ready = 1'b1;
    step();
    checks++; if (pop !== 5'b00100) begin failures++; $display("FAIL stall_header_pop got=%b exp=00100", pop); end
    step();
    fid[2] = P; fid[0] = H; req = 5'b00001;
    for (int k = 0; k < 3; k++) begin
      #1;
      checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL stall_out_valid k=%0d got=%b exp=0", k, out_valid); end
      checks++; if (grant !== 5'b00100) begin failures++; $display("FAIL stall_grant k=%0d got=%b exp=00100", k, grant); end
      checks++; if (pop !== 5'b0) begin failures++; $display("FAIL stall_pop k=%0d got=%b exp=00000", k, pop); end
      step();
    end
    req = 5'b00101; fid[2] = T;
    #1;
    checks++; if (pop !== 5'b00100) begin failures++; $display("FAIL stall_tail_pop got=%b exp=00100", pop); end
    step();
    checks++; if (grant !== 5'b0) begin failures++; $display("FAIL stall_release got=%b exp=00000", grant); end
    step();
    checks++; if (grant !== 5'b00001) begin failures++; $display("FAIL stall_next_owner got=%b exp=00001", grant); end
  endtask

  task automatic test_ready_low();
    do_reset();
    req = 5'b01000; fid[3] = H; out_ready = 1'b1;
    step();
    checks++; if (grant !== 5'b01000 || sel !== 3'd3) begin failures++; $display("FAIL ready_grant got grant=%b sel=%0d exp grant=01000 sel=3", grant, sel); end
    step();
    fid[3] = T; out_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      #1;
      checks++; if (grant !== 5'b01000 || busy !== 1'b1) begin failures++; $display("FAIL ready_hold k=%0d got grant=%b busy=%b exp grant=01000 busy=1", k, grant, busy); end
      checks++; if (pop !== 5'b0) begin failures++; $display("FAIL ready_pop k=%0d got=%b exp=00000", k, pop); end
      step();
    end
    out_ready = 1'b1;
    #1;
    checks++; if (pop !== 5'b01000) begin failures++; $display("FAIL ready_tail_pop got=%b exp=01000", pop); end
    step();
    checks++; if (busy !== 1'b0 || grant !== 5'b0) begin failures++; $display("FAIL ready_release got busy=%b grant=%b exp busy=0 grant=00000", busy, grant); end
  endtask

  task automatic test_reset_mid_packet();
    do_reset();
    req = 5'b01000; fid[3] = H; out_ready = 1'b1;
    step();
    step();
    fid[3] = P;
    #1;
    checks++; if (pop !== 5'b01000) begin failures++; $display("FAIL midrst_payload_pop got=%b exp=01000", pop); end
    #2;
    rst = 1'b0;
    #1;
    checks++; if (grant !== 5'b0 || sel !== 3'd0 || busy !== 1'b0) begin failures++; $display("FAIL midrst_regs got grant=%b sel=%0d busy=%b exp 0", grant, sel, busy); end
    checks++; if (out_valid !== 1'b0 || pop !== 5'b0 || timeout_err !== 1'b0) begin failures++; $display("FAIL midrst_comb got out_valid=%b pop=%b terr=%b exp 0", out_valid, pop, timeout_err); end
    req = 5'b11111; out_ready = 1'b0;
    for (int i = 0; i < 5; i++) fid[i] = H;
    step();
    rst = 1'b1;
    step();
    checks++; if (grant !== 5'b00001 || sel !== 3'd0) begin failures++; $display("FAIL midrst_first_arb got grant=%b sel=%0d exp grant=00001 sel=0", grant, sel); end
  endtask

`ifdef ARB_LOCK_TIMEOUT_EN
  task automatic test_timeout();
    do_reset();
    req = 5'b00100; fid[2] = H; out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    for (int k = 2; k <= 8; k++) begin
      step();
      checks++; if (grant !== 5'b00100 || timeout_err !== 1'b0) begin failures++; $display("FAIL to_hold edge=%0d got grant=%b terr=%b exp grant=00100 terr=0", k, grant, timeout_err); end
    end
    step();
    checks++; if (timeout_err !== 1'b1) begin failures++; $display("FAIL to_pulse got=%b exp=1", timeout_err); end
    checks++; if (grant !== 5'b0 || busy !== 1'b0) begin failures++; $display("FAIL to_release got grant=%b busy=%b exp grant=00000 busy=0", grant, busy); end
    req = 5'b01100; fid[3] = H;
    step();
    checks++; if (grant !== 5'b01000) begin failures++; $display("FAIL to_next_owner got=%b exp=01000", grant); end
    checks++; if (timeout_err !== 1'b0) begin failures++; $display("FAIL to_pulse_width got=%b exp=0", timeout_err); end
  endtask
`else
  task automatic test_lock_no_timeout();
    do_reset();
    req = 5'b00100; fid[2] = H; out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    for (int k = 0; k < 12; k++) begin
      step();
      checks++; if (grant !== 5'b00100 || timeout_err !== 1'b0) begin failures++; $display("FAIL nto_hold k=%0d got grant=%b terr=%b exp grant=00100 terr=0", k, grant, timeout_err); end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_empty_stall();
    test_ready_low();
    test_reset_mid_packet();
`ifdef ARB_LOCK_TIMEOUT_EN
    test_timeout();
`else
    test_lock_no_timeout();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
